// File: rtl/pattern_buffer_store.sv
// Pattern buffer: flop storage shared by the PAT field port, a host load port
// and a host dump streamer (valid/ready, one field every two cycles).
// Optional feature macro: PATBUF_DIRTY_EN adds per-buffer dirty flags.
module pattern_buffer_store #(
  parameter int unsigned d_width      = 8,
  parameter int unsigned bufp_width   = 3,
  parameter int unsigned fieldp_width = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [bufp_width+fieldp_width-1:0]  buf_fieldp,
  input  logic [bufp_width+fieldp_width-1:0]  buf_fieldwp,
  input  logic                                field_write_en,
  input  logic [d_width-1:0]                  field_in,
  output logic [d_width-1:0]                  field_out,
  input  logic                                load_en,
  input  logic [bufp_width+fieldp_width-1:0]  load_adr,
  input  logic [d_width-1:0]                  load_data,
  output logic                                load_collide,
  input  logic                                dump_req,
  input  logic [bufp_width-1:0]               dump_buf,
  output logic                                dump_busy,
  output logic                                dump_valid,
  input  logic                                dump_ready,
  output logic [d_width-1:0]                  dump_data,
  output logic [fieldp_width-1:0]             dump_field,
  output logic                                dump_last
`ifdef PATBUF_DIRTY_EN
  ,
  output logic [(1<<bufp_width)-1:0]          dirty
`endif
);

  localparam int unsigned AW    = bufp_width + fieldp_width;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, PRESENT, WAIT} state_t;

  logic [d_width-1:0]      mem [DEPTH];
  logic                    collide;

  state_t                  state_q, state_d;
  logic [bufp_width-1:0]   buf_q, buf_d;
  logic [fieldp_width-1:0] idx_q, idx_d;
  logic                    busy_d, valid_d, last_d;
  logic [d_width-1:0]      data_d;
  logic [fieldp_width-1:0] field_d;

  // PAT read port: zero-latency, no write bypass
  assign field_out = mem[buf_fieldp];

  // Host write is dropped when it targets the address the PAT writes this cycle
  assign collide = load_en && field_write_en && (load_adr == buf_fieldwp);

  // Storage with PAT priority over host on address collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (load_en && !collide) mem[load_adr] <= load_data;
      if (field_write_en)      mem[buf_fieldwp] <= field_in;
    end
  end

  // Collision flag pulses for one cycle after the dropped host write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) load_collide <= 1'b0;
    else        load_collide <= collide;
  end

  // Dump FSM state and registered stream outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      idx_q      <= '0;
      dump_busy  <= 1'b0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_field <= '0;
      dump_last  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      dump_busy  <= busy_d;
      dump_valid <= valid_d;
      dump_data  <= data_d;
      dump_field <= field_d;
      dump_last  <= last_d;
    end
  end

  // Dump next-state: capture a field, then hold it until the host accepts it
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    busy_d  = dump_busy;
    valid_d = dump_valid;
    data_d  = dump_data;
    field_d = dump_field;
    last_d  = dump_last;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          buf_d   = dump_buf;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        data_d  = mem[{buf_q, idx_q}];
        field_d = idx_q;
        last_d  = (idx_q == '1);
        valid_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (dump_valid && dump_ready) begin
          valid_d = 1'b0;
          if (dump_last) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = fieldp_width'(idx_q + 1'b1);
            state_d = PRESENT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PATBUF_DIRTY_EN
  logic                  final_hs;
  logic [bufp_width-1:0] wr_buf;

  assign final_hs = (state_q == WAIT) && dump_valid && dump_ready && dump_last;
  assign wr_buf   = buf_fieldwp[AW-1 -: bufp_width];

  // Dirty flags: PAT writes set, final dump handshake clears, set wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dirty <= '0;
    end else begin
      if (final_hs)       dirty[buf_q]  <= 1'b0;
      if (field_write_en) dirty[wr_buf] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pattern_buffer_store.sv
// Self-checking bench for pattern_buffer_store against an array-based model.
module tb_pattern_buffer_store;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] buf_fieldp, buf_fieldwp, load_adr;
  logic       field_write_en, load_en, dump_req, dump_ready;
  logic [7:0] field_in, load_data;
  logic [2:0] dump_buf;
  logic [7:0] field_out, dump_data;
  logic [4:0] dump_field;
  logic       load_collide, dump_busy, dump_valid, dump_last;
`ifdef PATBUF_DIRTY_EN
  logic [7:0] dirty;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mdl [256];
  logic [7:0] mdl_dirty;
  logic       exp_collide;
  logic       fin_hs;
  logic [2:0] dump_b;

  pattern_buffer_store dut (
    .clk(clk), .reset(reset),
    .buf_fieldp(buf_fieldp), .buf_fieldwp(buf_fieldwp),
    .field_write_en(field_write_en), .field_in(field_in), .field_out(field_out),
    .load_en(load_en), .load_adr(load_adr), .load_data(load_data),
    .load_collide(load_collide),
    .dump_req(dump_req), .dump_buf(dump_buf), .dump_busy(dump_busy),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_field(dump_field), .dump_last(dump_last)
`ifdef PATBUF_DIRTY_EN
    , .dirty(dirty)
`endif
  );

  always #5 clk = ~clk;

  task automatic clear_model();
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    mdl_dirty   = 8'h00;
    exp_collide = 1'b0;
  endtask

  // Apply this cycle's writes to the model, then advance one clock edge
  task automatic tick();
    logic c;
    c = load_en && field_write_en && (load_adr == buf_fieldwp);
    if (fin_hs) mdl_dirty[dump_b] = 1'b0;
    if (load_en && !c) mdl[load_adr] = load_data;
    if (field_write_en) begin
      mdl[buf_fieldwp] = field_in;
      mdl_dirty[buf_fieldwp[7:5]] = 1'b1;
    end
    exp_collide = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    field_write_en = 1'b0; load_en = 1'b0; dump_req = 1'b0; dump_ready = 1'b1;
    fin_hs = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int b, input bit rnd);
    for (int i = 0; i < 32; i++) begin
      load_en   = 1'b1;
      load_adr  = {3'(b), 5'(i)};
      load_data = rnd ? 8'($urandom) : 8'(i + 1);
      tick();
    end
    load_en = 1'b0;
  endtask

  // Run one dump, optionally stalling a beat (with PAT overwrites) or aborting by reset
  task automatic do_dump(input int b, input int stall_beat, input int stall_len,
                         input int abort_beat, output int nbeats, output int ncyc);
    logic [7:0] exp;
    bit         have;
    int         scnt;
    dump_req = 1'b1; dump_buf = 3'(b); dump_ready = 1'b1; dump_b = 3'(b);
    tick();
    dump_req = 1'b0;
    checks++;
    if (dump_busy !== 1'b1) begin errors++; $display("FAIL dump_busy_rise got %b exp 1", dump_busy); end
    nbeats = 0; ncyc = 0; scnt = 0; have = 0; exp = 8'h00;
    while (dump_busy && ncyc < 200) begin
      ncyc++;
      field_write_en = 1'b0;
      dump_ready = 1'b1;
      if (dump_valid) begin
        if (!have) begin
          have = 1;
          exp = mdl[{3'(b), 5'(nbeats)}];
        end
        checks++;
        if (dump_data !== exp || dump_field !== 5'(nbeats) || dump_last !== (nbeats == 31)) begin
          errors++;
          $display("FAIL dump_beat got d=%h f=%0d l=%b exp d=%h f=%0d l=%b",
                   dump_data, dump_field, dump_last, exp, nbeats, nbeats == 31);
        end
        if (nbeats == abort_beat) begin
          reset = 1'b0;
          #1;
          clear_model();
          checks++;
          if (dump_valid !== 1'b0 || dump_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort got valid=%b busy=%b exp 0 0", dump_valid, dump_busy);
          end
          @(negedge clk);
          reset = 1'b1;
          @(posedge clk);
          #1;
          break;
        end
        if (nbeats == stall_beat && scnt < stall_len) begin
          dump_ready = 1'b0;
          field_write_en = 1'b1;
          buf_fieldwp = {3'(b), 5'(nbeats + (scnt % 2))};
          field_in = ~exp ^ 8'(scnt);
          scnt++;
        end else begin
          fin_hs = (nbeats == 31);
          nbeats++;
          have = 0;
        end
      end
      tick();
      fin_hs = 1'b0;
    end
    field_write_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    clear_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    buf_fieldp = 8'h00; #1;
    checks++;
    if (field_out !== mdl[8'h00]) begin errors++; $display("FAIL reset_rd00 got %h exp %h", field_out, mdl[8'h00]); end
    buf_fieldp = 8'hFF; #1;
    checks++;
    if (field_out !== mdl[8'hFF]) begin errors++; $display("FAIL reset_rdFF got %h exp %h", field_out, mdl[8'hFF]); end
    checks++;
    if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || load_collide !== 1'b0 || dump_data !== 8'h00 ||
        dump_field !== 5'd0 || dump_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got v=%b b=%b c=%b d=%h f=%0d l=%b exp all 0",
               dump_valid, dump_busy, load_collide, dump_data, dump_field, dump_last);
    end
`ifdef PATBUF_DIRTY_EN
    checks++;
    if (dirty !== mdl_dirty) begin errors++; $display("FAIL reset_dirty got %h exp %h", dirty, mdl_dirty); end
`endif
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pat_rw();
    logic [7:0] old;
    old = mdl[8'h25];
    buf_fieldp = 8'h25; buf_fieldwp = 8'h25; field_in = 8'hA5; field_write_en = 1'b1;
    #1;
    checks++;
    if (field_out !== old) begin errors++; $display("FAIL rw_same_cycle got %h exp %h", field_out, old); end
    tick();
    field_write_en = 1'b0;
    #1;
    checks++;
    if (field_out !== 8'hA5) begin errors++; $display("FAIL rw_next_cycle got %h exp a5", field_out); end
  endtask

  task automatic test_collide();
    for (int k = 0; k < 2; k++) begin
      field_write_en = 1'b1; buf_fieldwp = 8'h40; field_in = 8'h11;
      load_en = 1'b1; load_adr = 8'(8'h40 + k); load_data = 8'h22;
      tick();
      field_write_en = 1'b0; load_en = 1'b0;
      checks++;
      if (load_collide !== exp_collide) begin
        errors++; $display("FAIL collide_pulse%0d got %b exp %b", k, load_collide, exp_collide);
      end
      buf_fieldp = 8'h40; #1;
      checks++;
      if (field_out !== 8'h11) begin errors++; $display("FAIL collide_mem40_%0d got %h exp 11", k, field_out); end
      buf_fieldp = 8'h41; #1;
      checks++;
      if (field_out !== mdl[8'h41]) begin errors++; $display("FAIL collide_mem41_%0d got %h exp %h", k, field_out, mdl[8'h41]); end
      tick();
      checks++;
      if (load_collide !== 1'b0) begin errors++; $display("FAIL collide_drop%0d got %b exp 0", k, load_collide); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      field_write_en = 1'($urandom_range(0, 1));
      load_en        = 1'($urandom_range(0, 1));
      buf_fieldwp    = 8'($urandom);
      load_adr       = ($urandom_range(0, 3) == 0) ? buf_fieldwp : 8'($urandom);
      field_in       = 8'($urandom);
      load_data      = 8'($urandom);
      buf_fieldp     = ($urandom_range(0, 1) == 0) ? buf_fieldwp : 8'($urandom);
      #1;
      checks++;
      if (field_out !== mdl[buf_fieldp]) begin
        errors++; $display("FAIL rand_read @%h got %h exp %h", buf_fieldp, field_out, mdl[buf_fieldp]);
      end
      tick();
      checks++;
      if (load_collide !== exp_collide) begin
        errors++; $display("FAIL rand_collide got %b exp %b", load_collide, exp_collide);
      end
    end
    idle_inputs();
  endtask

  task automatic test_dump_full();
    int nb, nc;
    preload(3, 0);
    do_dump(3, -1, 0, -1, nb, nc);
    checks++;
    if (nb != 32 || nc != 64) begin errors++; $display("FAIL dump_full got beats=%0d cyc=%0d exp 32 64", nb, nc); end
  endtask

  task automatic test_dump_stall();
    int nb, nc;
    do_dump(3, 4, 5, -1, nb, nc);
    checks++;
    if (nb != 32 || nc != 69) begin errors++; $display("FAIL dump_stall got beats=%0d cyc=%0d exp 32 69", nb, nc); end
  endtask

  task automatic test_reset_mid_dump();
    int nb, nc;
    do_dump(3, -1, 0, 10, nb, nc);
    preload(3, 1);
    do_dump(3, -1, 0, -1, nb, nc);
    checks++;
    if (nb != 32 || nc != 64) begin errors++; $display("FAIL dump_restart got beats=%0d cyc=%0d exp 32 64", nb, nc); end
  endtask

`ifdef PATBUF_DIRTY_EN
  task automatic test_dirty();
    int nb, nc;
    apply_reset();
    field_write_en = 1'b1; buf_fieldwp = 8'h47; field_in = 8'h5A;
    load_en = 1'b1; load_adr = 8'hA0; load_data = 8'h33;
    tick();
    field_write_en = 1'b0; load_en = 1'b0;
    checks++;
    if (dirty !== mdl_dirty) begin errors++; $display("FAIL dirty_set got %h exp %h", dirty, mdl_dirty); end
    do_dump(2, -1, 0, -1, nb, nc);
    checks++;
    if (dirty !== mdl_dirty) begin errors++; $display("FAIL dirty_clear got %h exp %h", dirty, mdl_dirty); end
  endtask
`endif

  initial begin
    buf_fieldp = 8'h00; buf_fieldwp = 8'h00; load_adr = 8'h00;
    field_in = 8'h00; load_data = 8'h00; dump_buf = 3'd0; dump_b = 3'd0;
    test_reset();
    test_pat_rw();
    test_collide();
    test_random();
    test_dump_full();
    test_dump_stall();
    test_reset_mid_dump();
`ifdef PATBUF_DIRTY_EN
    test_dirty();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
